// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl
//   Sequencer for a SIZE x SIZE systolic MAC array. The host fills the A and B
//   operand buffers while idle. On start the controller pulses the array
//   clear, streams skewed A rows / B columns into the array edges, waits for
//   the last operands to reach the far corner, and then drains the SIZE^2
//   accumulators over a valid/ready result stream in row-major order.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   start                   begin a multiply (sampled only in IDLE)
//   busy / done             state != IDLE / one-cycle pulse after last result
//   wr_en, wr_sel           buffer write strobe, 0 = A, 1 = B (IDLE only)
//   wr_row, wr_col, wr_data element index and operand byte
//   array_clear             accumulator clear (array reset = reset | clear)
//   a_in / valid_a          row feeds, lane i at a_in[8*i +: 8]
//   b_in / valid_b          column feeds, lane j at b_in[8*j +: 8]
//   acc_in                  accumulators, PE[r][c] at [32*(r*SIZE+c) +: 32]
//   res_valid/res_ready     result stream handshake
//   res_data/res_row/res_col  result value and its index
// ---------------------------------------------------------------------------

// One edge feed lane. Lane LANE starts its SIZE operands LANE cycles into
// FEED, which produces the diagonal skew the array needs. ops holds the
// SIZE operands of this lane, operand k at ops[8*k +: 8].
module systolic_feed_lane #(
  parameter int SIZE = 4,
  parameter int LANE = 0,
  parameter int TW   = 4
) (
  input  logic              feeding,
  input  logic [TW-1:0]     t,
  input  logic [SIZE*8-1:0] ops,
  output logic [7:0]        data,
  output logic              valid
);

  // t == LANE + k selects operand k; matching against constants avoids
  // signed arithmetic on t - LANE.
  always_comb begin
    data  = '0;
    valid = 1'b0;
    if (feeding) begin
      for (int k = 0; k < SIZE; k++) begin
        if (t == TW'(LANE + k)) begin
          data  = ops[k*8 +: 8];
          valid = 1'b1;
        end
      end
    end
  end

endmodule

module systolic_ctrl #(
  parameter int SIZE    = 4,
  parameter int MAC_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic                        wr_en,
  input  logic                        wr_sel,
  input  logic [$clog2(SIZE)-1:0]     wr_row,
  input  logic [$clog2(SIZE)-1:0]     wr_col,
  input  logic [7:0]                  wr_data,
  output logic                        array_clear,
  output logic [8*SIZE-1:0]           a_in,
  output logic [SIZE-1:0]             valid_a,
  output logic [8*SIZE-1:0]           b_in,
  output logic [SIZE-1:0]             valid_b,
  input  logic [32*SIZE*SIZE-1:0]     acc_in,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [31:0]                 res_data,
  output logic [$clog2(SIZE)-1:0]     res_row,
  output logic [$clog2(SIZE)-1:0]     res_col
);

  localparam int RW         = $clog2(SIZE);
  localparam int IW         = $clog2(SIZE*SIZE);
  // Shared phase counter covers FEED (0..2*SIZE-2) and DRAIN (0..SIZE-2+MAC_LAT).
  localparam int CW         = $clog2(3*SIZE + MAC_LAT);
  localparam int FEED_LAST  = 2*SIZE - 2;
  localparam int DRAIN_LAST = SIZE - 2 + MAC_LAT;
  localparam int LAST_IDX   = SIZE*SIZE - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_OUTPUT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            done_q;
  logic            hs_last;
  logic            feeding;

  // Operand buffers: a_buf[row][col], b_buf[row][col].
  logic [SIZE-1:0][SIZE-1:0][7:0] a_buf, b_buf;
  // B transposed so each column lane sees its operands as one packed vector.
  logic [SIZE-1:0][SIZE-1:0][7:0] b_col;

  // ---------------------------------------------------------------------
  // Operand buffers: writable only while idle, cleared by reset.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_buf <= '0;
      b_buf <= '0;
    end else if (state_q == ST_IDLE && wr_en) begin
      if (wr_sel) b_buf[wr_row][wr_col] <= wr_data;
      else        a_buf[wr_row][wr_col] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= hs_last;
    end
  end

  assign hs_last = (state_q == ST_OUTPUT) && res_ready && (idx_q == IW'(LAST_IDX));

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        cnt_d   = '0;
      end
      ST_FEED: begin
        if (cnt_q == CW'(FEED_LAST)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CW'(DRAIN_LAST)) begin
          state_d = ST_OUTPUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (res_ready) begin
          if (idx_q == IW'(LAST_IDX)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Status and result outputs
  // ---------------------------------------------------------------------
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign array_clear = (state_q == ST_CLEAR);
  assign res_valid   = (state_q == ST_OUTPUT);
  assign feeding     = (state_q == ST_FEED);

  // Row-major idx maps directly onto the flat accumulator bus.
  assign res_row = RW'(idx_q / IW'(SIZE));
  assign res_col = RW'(idx_q % IW'(SIZE));

  always_comb begin
    res_data = '0;
    for (int k = 0; k < SIZE*SIZE; k++) begin
      if (idx_q == IW'(k)) res_data = acc_in[k*32 +: 32];
    end
  end

  // ---------------------------------------------------------------------
  // Edge feed lanes
  // ---------------------------------------------------------------------
  for (genvar j = 0; j < SIZE; j++) begin : g_bcol
    for (genvar r = 0; r < SIZE; r++) begin : g_brow
      assign b_col[j][r] = b_buf[r][j];
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    systolic_feed_lane #(.SIZE(SIZE), .LANE(i), .TW(CW)) u_a_lane (
      .feeding (feeding),
      .t       (cnt_q),
      .ops     (a_buf[i]),
      .data    (a_in[i*8 +: 8]),
      .valid   (valid_a[i])
    );
    systolic_feed_lane #(.SIZE(SIZE), .LANE(i), .TW(CW)) u_b_lane (
      .feeding (feeding),
      .t       (cnt_q),
      .ops     (b_col[i]),
      .data    (b_in[i*8 +: 8]),
      .valid   (valid_b[i])
    );
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_ctrl
//   Drives systolic_ctrl (SIZE=4, MAC_LAT=1) against a behavioural systolic
//   array (registered PEs passing A right and B down, accumulating when both
//   operands are valid). Expected products come from a table of hand-derived
//   matrices; feed skew is compared each FEED cycle against the diagonal
//   formula using the bench's own copy of the written operands.
// ---------------------------------------------------------------------------
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int ML = 1;

  logic                 clk = 1'b0;
  logic                 reset, start, busy, done;
  logic                 wr_en, wr_sel;
  logic [1:0]           wr_row, wr_col;
  logic [7:0]           wr_data;
  logic                 array_clear;
  logic [8*N-1:0]       a_in, b_in;
  logic [N-1:0]         valid_a, valid_b;
  logic [32*N*N-1:0]    acc_in;
  logic                 res_valid, res_ready;
  logic [31:0]          res_data;
  logic [1:0]           res_row, res_col;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  systolic_ctrl #(.SIZE(N), .MAC_LAT(ML)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .array_clear(array_clear),
    .a_in(a_in), .valid_a(valid_a), .b_in(b_in), .valid_b(valid_b),
    .acc_in(acc_in), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row), .res_col(res_col)
  );

  // ------------------------- array model --------------------------------
  logic [7:0]  pa [N][N];
  logic [7:0]  pb [N][N];
  logic        pva[N][N];
  logic        pvb[N][N];
  logic [31:0] acc[N][N];
  logic [7:0]  ia [N][N];
  logic [7:0]  ib [N][N];
  logic        iva[N][N];
  logic        ivb[N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) begin
          ia[i][j]  = a_in[i*8 +: 8];
          iva[i][j] = valid_a[i];
        end else begin
          ia[i][j]  = pa[i][j-1];
          iva[i][j] = pva[i][j-1];
        end
        if (i == 0) begin
          ib[i][j]  = b_in[j*8 +: 8];
          ivb[i][j] = valid_b[j];
        end else begin
          ib[i][j]  = pb[i-1][j];
          ivb[i][j] = pvb[i-1][j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (reset || array_clear) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          pva[i][j] <= 1'b0;
          pvb[i][j] <= 1'b0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j]  <= ia[i][j];
          pb[i][j]  <= ib[i][j];
          pva[i][j] <= iva[i][j];
          pvb[i][j] <= ivb[i][j];
          if (iva[i][j] && ivb[i][j])
            acc[i][j] <= acc[i][j] + 32'(ia[i][j]) * 32'(ib[i][j]);
        end
      end
    end
  end

  always_comb begin
    acc_in = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        acc_in[(i*N+j)*32 +: 32] = acc[i][j];
  end

  // ------------------------- vectors ------------------------------------
  typedef struct packed {
    logic                        load_a;
    logic                        load_b;
    logic                        stall;    // 5-cycle stall at idx 0 then toggle ready
    logic                        disturb;  // start + write A[0][0]=0x77 during FEED
    logic [N-1:0][N-1:0][7:0]    a;
    logic [N-1:0][N-1:0][7:0]    b;
    logic [N-1:0][N-1:0][31:0]   exp;
  } vec_t;

  vec_t       tbl [6];
  vec_t       zvec;
  logic [7:0] sh_a [N][N];
  logic [7:0] sh_b [N][N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_shadow();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        sh_a[r][c] = '0;
        sh_b[r][c] = '0;
      end
  endtask

  // Loads the requested buffers and asserts start together with the last
  // write (or alone); returns one cycle after the start edge (CLEAR).
  task automatic kick(input vec_t v);
    int total, n;
    total = (v.load_a ? N*N : 0) + (v.load_b ? N*N : 0);
    n = 0;
    for (int s = 0; s < 2; s++) begin
      if ((s == 0 && v.load_a) || (s == 1 && v.load_b)) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            n++;
            wr_en   = 1'b1;
            wr_sel  = (s == 1);
            wr_row  = 2'(r);
            wr_col  = 2'(c);
            wr_data = (s == 1) ? v.b[r][c] : v.a[r][c];
            start   = (n == total);
            if (s == 1) sh_b[r][c] = v.b[r][c];
            else        sh_a[r][c] = v.a[r][c];
            step();
          end
        end
      end
    end
    if (total == 0) begin
      start = 1'b1;
      step();
    end
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic chk_feeds(input int t);
    logic [7:0] ea, eb;
    logic       eva, evb;
    for (int i = 0; i < N; i++) begin
      ea = '0; eva = 1'b0; eb = '0; evb = 1'b0;
      if (t >= 0 && t - i >= 0 && t - i < N) begin
        ea = sh_a[i][t-i]; eva = 1'b1;
        eb = sh_b[t-i][i]; evb = 1'b1;
      end
      chk("feed_a", 32'({valid_a[i], a_in[i*8 +: 8]}), 32'({eva, ea}));
      chk("feed_b", 32'({valid_b[i], b_in[i*8 +: 8]}), 32'({evb, eb}));
    end
  endtask

  task automatic run_op(input vec_t v);
    int  k, oc;
    logic rdy;
    kick(v);
    // cycle 1 after the start edge: CLEAR
    chk("clr_busy",  32'(busy), 1);
    chk("clr_pulse", 32'(array_clear), 1);
    chk("done_low",  32'(done), 0);
    chk_feeds(-1);
    for (int e = 1; e <= 11; e++) begin
      step();
      if (e == 4 && v.disturb) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      chk("run_busy",  32'(busy), 1);
      chk("run_clear", 32'(array_clear), 0);
      chk("early_res", 32'(res_valid), 0);
      if (e <= 2*N-1) chk_feeds(e - 1);
      else            chk_feeds(-1);
      if (e == 3 && v.disturb) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_row  = 2'd0;
        wr_col  = 2'd0;
        wr_data = 8'h77;
      end
    end
    step();
    chk("first_valid", 32'(res_valid), 1);
    k = 0;
    oc = 0;
    while (k < N*N && oc < 200) begin
      chk("res_valid", 32'(res_valid), 1);
      chk("res_row",   32'(res_row), 32'(k / N));
      chk("res_col",   32'(res_col), 32'(k % N));
      chk("res_data",  res_data, v.exp[k / N][k % N]);
      rdy = v.stall ? ((oc >= 5) && ((oc - 5) % 2 == 0)) : 1'b1;
      res_ready = rdy;
      step();
      if (rdy) k++;
      oc++;
    end
    res_ready = 1'b0;
    chk("drain_count", 32'(k), N*N);
    chk("done_pulse",  32'(done), 1);
    chk("idle_busy",   32'(busy), 0);
    chk("idle_valid",  32'(res_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 6; n++) tbl[n] = '0;
    zvec = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        // 0: identity x (4r+c) -> 4r+c; last write also carries start
        tbl[0].load_a = 1; tbl[0].load_b = 1;
        tbl[0].a[r][c] = (r == c) ? 8'd1 : 8'd0;
        tbl[0].b[r][c] = 8'(4*r + c);
        tbl[0].exp[r][c] = 32'(4*r + c);
        // 1: all 255 -> 4*255*255, stalled output
        tbl[1].load_a = 1; tbl[1].load_b = 1; tbl[1].stall = 1;
        tbl[1].a[r][c] = 8'd255;
        tbl[1].b[r][c] = 8'd255;
        tbl[1].exp[r][c] = 32'd260100;
        // 2: ones x (4r+c) -> 24+4c, disturbed during FEED
        tbl[2].load_a = 1; tbl[2].load_b = 1; tbl[2].disturb = 1;
        tbl[2].a[r][c] = 8'd1;
        tbl[2].b[r][c] = 8'(4*r + c);
        tbl[2].exp[r][c] = 32'(24 + 4*c);
        // 3: rerun, no writes, started in the done cycle
        tbl[3].stall = 1;
        tbl[3].exp[r][c] = 32'(24 + 4*c);
        // 4: new B = identity, A still ones -> all 1
        tbl[4].load_b = 1;
        tbl[4].b[r][c] = (r == c) ? 8'd1 : 8'd0;
        tbl[4].exp[r][c] = 32'd1;
        // 5: new A = 2*identity, B identity -> 2 on diagonal
        tbl[5].load_a = 1;
        tbl[5].a[r][c] = (r == c) ? 8'd2 : 8'd0;
        tbl[5].exp[r][c] = (r == c) ? 32'd2 : 32'd0;
      end
    end

    reset = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0; res_ready = 1'b0;
    clear_shadow();
    step();
    step();
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_clear", 32'(array_clear), 0);
    chk("rst_feeds", 32'({valid_a, valid_b}), 0);
    reset = 1'b0;
    step();

    for (int n = 0; n < 6; n++) run_op(tbl[n]);

    // Reset at FEED t=3 aborts; buffers and accumulators come back empty.
    step();
    kick(tbl[0]);
    for (int e = 1; e <= 4; e++) step();
    chk_feeds(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_shadow();
    chk("abort_busy",  32'(busy), 0);
    chk("abort_feeds", 32'({valid_a, valid_b, a_in, b_in}), 0);
    chk("abort_done",  32'(done), 0);
    chk("abort_valid", 32'(res_valid), 0);
    step();
    chk("abort_done2", 32'(done), 0);
    chk("abort_idle",  32'(busy), 0);
    run_op(zvec);
    run_op(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
